// File: rtl/iob_ptfloat_unpack_pkg.sv
// Shared definitions for the ptfloat unpacker: FSM encoding and derived-width helpers.
// The same widths are used by the downstream ptfloat-to-double converter.
package iob_ptfloat_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Exponent output width: widest exponent an EW_W-bit width field can describe.
    function automatic int exp_max_w(input int ew_w);
        return (2 ** ew_w) - 1;
    endfunction

    // Mantissa output width: everything below the exponent-width field.
    function automatic int man_max_w(input int data_w, input int ew_w);
        return data_w - ew_w;
    endfunction

endpackage

// File: rtl/iob_ptfloat_unpack.sv
// Iterative ptfloat unpacker: shifts the variable-width exponent out of the payload
// one bit per enabled cycle, leaving the mantissa MSB-aligned.
module iob_ptfloat_unpack
    import iob_ptfloat_unpack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     start_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     zero_o,
    output logic [(2**EW_W)-2:0]     exp_o,
    output logic [DATA_W-EW_W-1:0]   man_o
);

    localparam int EXP_MAX_W = exp_max_w(EW_W);
    localparam int P         = man_max_w(DATA_W, EW_W);

    state_t               state;
    logic [EW_W-1:0]      cnt;
    logic [P-1:0]         shreg;
    logic [EXP_MAX_W-1:0] exp_acc;

    logic [EW_W-1:0]      ew_in;
    logic [P-1:0]         payload;
    logic [EXP_MAX_W-1:0] shift_exp;
    logic [P-1:0]         shift_man;

    // Field split of the incoming word and the next shift-step values.
    always_comb begin
        ew_in     = data_i[DATA_W-1 -: EW_W];
        payload   = data_i[P-1:0];
        shift_exp = {exp_acc[EXP_MAX_W-2:0], shreg[P-1]};
        shift_man = {shreg[P-2:0], 1'b0};
    end

    // Control FSM, shift datapath and registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            exp_acc <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            zero_o  <= 1'b0;
            exp_o   <= '0;
            man_o   <= '0;
        end else if (cke_i) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        shreg <= payload;
                        cnt   <= ew_in;
                        if (ew_in != '0) begin
                            // Pre-fill with the exponent sign so shifted-in bits end up sign-extended.
                            exp_acc <= {EXP_MAX_W{payload[P-1]}};
                            state   <= ST_SHIFT;
                            busy_o  <= 1'b1;
                        end else begin
                            exp_acc <= '0;
                            state   <= ST_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            man_o   <= payload;
                            zero_o  <= (payload == '0);
                            exp_o   <= '0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    exp_acc <= shift_exp;
                    shreg   <= shift_man;
                    cnt     <= cnt - EW_W'(1);
                    if (cnt == EW_W'(1)) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        man_o  <= shift_man;
                        zero_o <= (shift_man == '0);
                        // A zero mantissa is reported with a canonical zero exponent.
                        exp_o  <= (shift_man == '0) ? '0 : shift_exp;
                    end else begin
                        state  <= ST_SHIFT;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Directed bench for iob_ptfloat_unpack: expected results go into a scoreboard queue
// that a negedge monitor drains on every enabled done_o pulse.
module tb_iob_ptfloat_unpack;

    logic        clk = 1'b0;
    logic        arst;
    logic        cke;
    logic        start;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        zero;
    logic [14:0] exp_v;
    logic [27:0] man_v;

    int total = 0;
    int bad   = 0;
    logic en_q = 1'b0;

    typedef struct packed {
        logic [14:0] e;
        logic [27:0] m;
        logic        z;
    } res_t;

    res_t sb_q[$];

    iob_ptfloat_unpack #(.DATA_W(32), .EW_W(4)) dut (
        .clk_i   (clk),
        .arst_i  (arst),
        .cke_i   (cke),
        .start_i (start),
        .data_i  (data),
        .busy_o  (busy),
        .done_o  (done),
        .zero_o  (zero),
        .exp_o   (exp_v),
        .man_o   (man_v)
    );

    always #5 clk = ~clk;

    // Remember whether the last rising edge was an enabled one.
    always @(posedge clk) en_q = cke;

    // Monitor: each enabled done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        res_t x;
        if (!arst && en_q && done) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got exp=%h man=%h zero=%b, none expected", exp_v, man_v, zero);
            end else begin
                x = sb_q.pop_front();
                if (exp_v !== x.e || man_v !== x.m || zero !== x.z) begin
                    bad++;
                    $display("FAIL result got exp=%h man=%h zero=%b want exp=%h man=%h zero=%b",
                             exp_v, man_v, zero, x.e, x.m, x.z);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Issue one word (caller is just after a rising edge) and wait for done_o.
    task automatic run(input string name, input logic [31:0] d, input int ew,
                       input logic [14:0] e, input logic [27:0] m, input logic z,
                       input int stall_at, input int repulse_at);
        int lat;
        int bsy;
        int n;
        int stall_left;
        bit stalled;
        sb_q.push_back({e, m, z});
        start = 1'b1;
        data  = d;
        @(posedge clk); #1;
        start = 1'b0;
        data  = 32'h0;
        lat = 1; bsy = 0; n = 1; stall_left = 0; stalled = 1'b0;
        while (!done && n < 60) begin
            if (busy && en_q) bsy++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) cke = 1'b1;
            end else if (!stalled && en_q && lat == stall_at) begin
                cke = 1'b0;
                stall_left = 2;
                stalled = 1'b1;
            end
            if (en_q && lat == repulse_at) begin
                start = 1'b1;
                data  = 32'h04000000;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            data  = 32'h0;
            if (en_q) lat++;
        end
        chk({name, "_latency"}, lat, ew + 1);
        chk({name, "_cycles"}, n, ew + 1 + (stall_at > 0 ? 2 : 0));
        chk({name, "_busy_cycles"}, bsy, ew);
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_zero"}, zero, 1'b0);
        chk({name, "_exp"}, exp_v, 15'h0);
        chk({name, "_man"}, man_v, 28'h0);
    endtask

    initial begin
        arst  = 1'b1;
        cke   = 1'b1;
        start = 1'b0;
        data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        arst = 1'b0;
        idle(1);

        run("ew3",      32'h3A800000, 3,  15'h7FFD, 28'h4000000, 1'b0, 0, 0);
        idle(2);
        run("ew0",      32'h04000000, 0,  15'h0000, 28'h4000000, 1'b0, 0, 0);
        idle(2);
        run("ew15",     32'hF7FFE800, 15, 15'h3FFF, 28'h4000000, 1'b0, 0, 0);
        idle(2);
        run("neg",      32'h1E000000, 1,  15'h7FFF, 28'hC000000, 1'b0, 0, 0);
        idle(2);
        run("zero",     32'h3A000000, 3,  15'h0000, 28'h0000000, 1'b1, 0, 0);
        idle(2);
        run("repulse",  32'h3A800000, 3,  15'h7FFD, 28'h4000000, 1'b0, 0, 2);
        // Next word is presented during the DONE cycle of the previous one.
        run("b2b",      32'h04000000, 0,  15'h0000, 28'h4000000, 1'b0, 0, 0);
        idle(2);
        run("cke_stall", 32'h3A800000, 3, 15'h7FFD, 28'h4000000, 1'b0, 2, 0);
        idle(2);

        // Reset in the middle of SHIFT: nothing queued, so any done_o is flagged.
        start = 1'b1;
        data  = 32'h3A800000;
        @(posedge clk); #1;
        start = 1'b0;
        data  = 32'h0;
        @(posedge clk); #1;
        chk("midshift_busy", busy, 1'b1);
        arst = 1'b1;
        #1;
        chk_zero_outputs("midshift_reset");
        @(posedge clk); #1;
        arst = 1'b0;
        idle(8);
        chk("after_reset_busy", busy, 1'b0);
        run("post_reset", 32'h1E000000, 1, 15'h7FFF, 28'hC000000, 1'b0, 0, 0);
        idle(2);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
